// File: rtl/shot_sequencer.sv
// Shot sequencer: holds a small table of shot configurations and, while
// enabled, presents them round-robin to the pulser at a fixed repetition
// period, each followed by a multi-cycle sync strobe.
module shot_sequencer #(
    parameter int NSLOT    = 8,
    parameter int PERIOD_W = 24,
    parameter int SYNC_LEN = 4
) (
    input  logic                hi_clk,
    input  logic                rst_n,
    input  logic                i_enable,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [2:0]          i_slot_count,
    input  logic                i_wr,
    input  logic [2:0]          i_wr_addr,
    input  logic [24:0]         i_wr_data,
    output logic                o_sync,
    output logic [2:0]          o_rx_mask,
    output logic [2:0]          o_tx_mask,
    output logic [2:0]          o_pulse_count,
    output logic [7:0]          o_pulse_width,
    output logic [7:0]          o_pulse_pause,
    output logic [2:0]          o_slot,
    output logic                o_frame_start,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SYNC = 2'd2,
        WAIT = 2'd3
    } state_t;

    // Slots beyond the configured depth alias onto the real ones.
    localparam logic [2:0]          SLOT_MASK  = 3'(NSLOT - 1);
    // Shortest period that still leaves two low cycles after the sync strobe.
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(SYNC_LEN + 2);
    localparam logic [PERIOD_W-1:0] SYNC_END   = PERIOD_W'(SYNC_LEN);

    state_t              state_q, state_d;
    logic [2:0]          slot_q, slot_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_eff;
    logic                load_en;
    logic [2:0]          slot_next;
    logic [24:0]         table_q [8];
    logic [24:0]         rd_data;

    logic [2:0]          rx_q, tx_q, count_q;
    logic [7:0]          width_q, pause_q;
    logic [2:0]          slot_out_q;

    assign period_eff = (i_period < MIN_PERIOD) ? MIN_PERIOD : i_period;
    assign slot_next  = (slot_q >= i_slot_count) ? 3'd0 : slot_q + 3'd1;
    assign rd_data    = table_q[slot_q & SLOT_MASK];

    // Configuration table; a write in the LOAD cycle is seen on the next visit.
    always_ff @(posedge hi_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                table_q[i] <= '0;
            end
        end else if (i_wr) begin
            table_q[i_wr_addr & SLOT_MASK] <= i_wr_data;
        end
    end

    // Sequencer state, slot index and shot counter.
    always_ff @(posedge hi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter is 0 in LOAD so LOAD-to-LOAD is exactly P cycles.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q + PERIOD_W'(1);
        load_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                slot_d = 3'd0;
                if (i_enable) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                state_d = SYNC;
            end
            SYNC: begin
                if (cnt_q == SYNC_END) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == period_q - PERIOD_W'(1)) begin
                    cnt_d = '0;
                    if (i_enable) begin
                        slot_d  = slot_next;
                        state_d = LOAD;
                    end else begin
                        slot_d  = 3'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shot parameters and period are captured in LOAD and held until the next LOAD.
    always_ff @(posedge hi_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q       <= '0;
            tx_q       <= '0;
            count_q    <= '0;
            width_q    <= '0;
            pause_q    <= '0;
            slot_out_q <= '0;
            period_q   <= '0;
        end else if (load_en) begin
            rx_q       <= rd_data[24:22];
            tx_q       <= rd_data[21:19];
            count_q    <= rd_data[18:16];
            width_q    <= rd_data[15:8];
            pause_q    <= rd_data[7:0];
            slot_out_q <= slot_q;
            period_q   <= period_eff;
        end
    end

    assign o_sync        = (state_q == SYNC);
    assign o_busy        = (state_q != IDLE);
    assign o_frame_start = (state_q == LOAD) && (slot_q == 3'd0);
    assign o_rx_mask     = rx_q;
    assign o_tx_mask     = tx_q;
    assign o_pulse_count = count_q;
    assign o_pulse_width = width_q;
    assign o_pulse_pause = pause_q;
    assign o_slot        = slot_out_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed testbench for shot_sequencer with a scoreboard of expected shots.
module tb_shot_sequencer;

    logic        hi_clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic [23:0] i_period;
    logic [2:0]  i_slot_count;
    logic        i_wr;
    logic [2:0]  i_wr_addr;
    logic [24:0] i_wr_data;
    logic        o_sync;
    logic [2:0]  o_rx_mask, o_tx_mask, o_pulse_count, o_slot;
    logic [7:0]  o_pulse_width, o_pulse_pause;
    logic        o_frame_start, o_busy;

    typedef struct packed {
        logic [2:0]  slot;
        logic [24:0] data;
    } shot_t;

    shot_t       sbQ[$];
    logic [24:0] tbl [8];
    int          nAsserts = 0;
    int          nFail    = 0;
    int          cycle    = 0;
    int          lastRise = 0;

    shot_sequencer #(.NSLOT(8), .PERIOD_W(24), .SYNC_LEN(4)) dut (
        .hi_clk        (hi_clk),
        .rst_n         (rst_n),
        .i_enable      (i_enable),
        .i_period      (i_period),
        .i_slot_count  (i_slot_count),
        .i_wr          (i_wr),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_sync        (o_sync),
        .o_rx_mask     (o_rx_mask),
        .o_tx_mask     (o_tx_mask),
        .o_pulse_count (o_pulse_count),
        .o_pulse_width (o_pulse_width),
        .o_pulse_pause (o_pulse_pause),
        .o_slot        (o_slot),
        .o_frame_start (o_frame_start),
        .o_busy        (o_busy)
    );

    // Free-running 10-unit clock.
    always #5 hi_clk = ~hi_clk;

    function automatic logic [24:0] params();
        return {o_rx_mask, o_tx_mask, o_pulse_count, o_pulse_width, o_pulse_pause};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; write strobes last exactly one cycle.
    task automatic tick();
        @(negedge hi_clk);
        cycle++;
        i_wr = 1'b0;
    endtask

    task automatic pushShot(input logic [2:0] slot);
        shot_t s;
        s.slot = slot;
        s.data = tbl[slot];
        sbQ.push_back(s);
    endtask

    task automatic writeSlot(input logic [2:0] addr, input logic [24:0] data);
        i_wr      = 1'b1;
        i_wr_addr = addr;
        i_wr_data = data;
        tbl[addr] = data;
        tick();
    endtask

    // Wait for a sync rise, compare against the scoreboard, then measure the high time.
    task automatic runShot(input string tag, input int expSpacing, input int dropAt);
        logic  prevS, prevFs;
        bit    found;
        int    hi;
        shot_t e;
        found  = 1'b0;
        prevS  = o_sync;
        prevFs = o_frame_start;
        for (int n = 0; n < 300 && !found; n++) begin
            tick();
            if (o_sync && !prevS) found = 1'b1;
            else begin
                prevS  = o_sync;
                prevFs = o_frame_start;
            end
        end
        check({tag, "_rise"}, 32'(found), 32'd1);
        check({tag, "_sbq"}, 32'(sbQ.size() != 0), 32'd1);
        if (!found || sbQ.size() == 0) return;
        e = sbQ.pop_front();
        check({tag, "_slot"}, 32'(o_slot), 32'(e.slot));
        check({tag, "_params"}, 32'(params()), 32'(e.data));
        check({tag, "_frame"}, 32'(prevFs), 32'(e.slot == 3'd0));
        if (expSpacing > 0) check({tag, "_spacing"}, 32'(cycle - lastRise), 32'(expSpacing));
        lastRise = cycle;
        hi = 1;
        for (int n = 0; n < 20; n++) begin
            if (hi == dropAt) i_enable = 1'b0;
            tick();
            if (!o_sync) break;
            hi++;
        end
        check({tag, "_synclen"}, 32'(hi), 32'd4);
        check({tag, "_stable"}, 32'(params()), 32'(e.data));
    endtask

    task automatic waitIdle(input string tag, input int expCycles);
        int  n;
        bit  found;
        found = 1'b0;
        n     = 0;
        while (n < 300 && !found) begin
            tick();
            n++;
            if (!o_busy) found = 1'b1;
        end
        check({tag, "_idle"}, 32'(found), 32'd1);
        if (expCycles >= 0) check({tag, "_idlecyc"}, 32'(n), 32'(expCycles));
    endtask

    initial begin
        rst_n        = 1'b0;
        i_enable     = 1'b1;
        i_period     = 24'd100;
        i_slot_count = 3'd2;
        i_wr         = 1'b0;
        i_wr_addr    = 3'd0;
        i_wr_data    = '0;
        for (int i = 0; i < 8; i++) tbl[i] = '0;

        // Reset held with enable high: everything quiet, then LOAD right after release.
        tick();
        tick();
        check("rst_outs", 32'({o_sync, o_frame_start, o_busy, o_slot, params()}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("lat_load", 32'({o_frame_start, o_busy, o_sync}), 32'b110);
        tick();
        check("lat_sync", 32'({o_sync, o_slot}), 32'b1000);
        i_enable = 1'b0;
        waitIdle("first", 99);

        // Three slots round-robin at period 100; slot 2 carries a zero pulse count.
        writeSlot(3'd0, {3'd5, 3'd3, 3'd4, 8'd10, 8'd20});
        writeSlot(3'd1, {3'd1, 3'd6, 3'd2, 8'hA5, 8'h5A});
        writeSlot(3'd2, {3'd7, 3'd7, 3'd0, 8'd1, 8'd255});
        for (int r = 0; r < 2; r++) for (int s = 0; s < 3; s++) pushShot(3'(s));
        i_enable = 1'b1;
        runShot("rr0", 0, 0);
        for (int k = 1; k < 6; k++) runShot($sformatf("rr%0d", k), 100, 0);

        // Period below the minimum clamps to SYNC_LEN+2 from the next LOAD on.
        i_period = 24'd3;
        pushShot(3'd0); pushShot(3'd1); pushShot(3'd2);
        runShot("clampA", 100, 0);
        runShot("clampB", 6, 0);
        runShot("clampC", 6, 0);

        // Enable dropped inside SYNC: strobe completes, stop at the period boundary.
        pushShot(3'd0); pushShot(3'd1);
        runShot("dropA", 6, 0);
        runShot("dropB", 6, 2);
        waitIdle("drop", 1);
        check("drop_slot", 32'(o_slot), 32'd1);
        check("drop_sync", 32'(o_sync), 32'd0);

        // Write to slot 1 during its own LOAD: old data now, new data next visit.
        pushShot(3'd0); pushShot(3'd1);
        i_enable = 1'b1;
        runShot("colA", 0, 0);
        tick();
        check("col_loadcyc", 32'({o_busy, o_sync}), 32'b10);
        i_wr      = 1'b1;
        i_wr_addr = 3'd1;
        i_wr_data = {3'd2, 3'd1, 3'd7, 8'h33, 8'hCC};
        runShot("colB", 6, 0);
        tbl[1] = {3'd2, 3'd1, 3'd7, 8'h33, 8'hCC};
        pushShot(3'd2); pushShot(3'd0); pushShot(3'd1);
        runShot("colC", 6, 0);
        runShot("colD", 6, 0);
        runShot("colE", 6, 0);

        // Asynchronous reset during WAIT clears outputs immediately and the table.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outs", 32'({o_sync, o_busy, o_frame_start, o_slot, params()}), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tbl[i] = '0;
        pushShot(3'd0);
        runShot("post", 0, 0);
        i_enable = 1'b0;
        waitIdle("final", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
